// File: rtl/prog_loader.sv
// Loads a length-prefixed byte stream into word-addressed memory, packing bytes little-endian
// and holding the core in reset until the image is complete.
module prog_loader #(
  parameter int DEPTH         = 16384,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [ADDRESS_WIDTH-3:0] mem_addr,
  output logic [31:0]              mem_data,
  output logic [3:0]               mem_wstrb,
  output logic                     mem_we,
  output logic                     cpu_rst_n,
  output logic                     done,
  output logic                     error
);

  // state   | meaning
  // S_LEN   | collecting the 4 length bytes; idle when none received yet
  // S_DATA  | packing payload bytes into the word buffer
  // S_WRITE | one-cycle memory write of the packed word
  // S_DONE  | load complete pulse, core about to be released
  // S_ERROR | length exceeded memory; discard everything until rst_n
  typedef enum logic [2:0] {S_LEN, S_DATA, S_WRITE, S_DONE, S_ERROR} state_t;

  localparam int RW = ADDRESS_WIDTH + 1;

  state_t          state;
  logic [1:0]      hdr_cnt;
  logic [23:0]     len_lo;
  logic [RW-1:0]   remaining;
  logic [1:0]      lane;
  logic            accept;
  logic [31:0]     len_full;

  assign accept   = rx_valid && rx_ready;
  assign len_full = {rx_data, len_lo};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_LEN;
      hdr_cnt   <= '0;
      len_lo    <= '0;
      remaining <= '0;
      lane      <= '0;
      rx_ready  <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_wstrb <= '0;
      mem_we    <= 1'b0;
      cpu_rst_n <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_LEN: begin
          rx_ready <= 1'b1;
          if (accept) begin
            cpu_rst_n <= 1'b0;
            hdr_cnt   <= hdr_cnt + 2'd1;
            if (hdr_cnt != 2'd3) begin
              len_lo[8*hdr_cnt +: 8] <= rx_data;
            end else if (len_full == 32'd0) begin
              state    <= S_DONE;
              rx_ready <= 1'b0;
              done     <= 1'b1;
            end else if (len_full > 32'(DEPTH)) begin
              state <= S_ERROR;
              error <= 1'b1;
            end else begin
              state     <= S_DATA;
              remaining <= len_full[RW-1:0];
              lane      <= '0;
              mem_addr  <= '0;
              mem_data  <= '0;
              mem_wstrb <= '0;
            end
          end else if (hdr_cnt == 2'd0) begin
            cpu_rst_n <= 1'b1;
          end
        end
        S_DATA: begin
          if (accept) begin
            mem_data[8*lane +: 8] <= rx_data;
            mem_wstrb[lane]       <= 1'b1;
            lane                  <= lane + 2'd1;
            remaining             <= remaining - RW'(1);
            if (lane == 2'd3 || remaining == RW'(1)) begin
              state    <= S_WRITE;
              mem_we   <= 1'b1;
              rx_ready <= 1'b0;
            end
          end
        end
        S_WRITE: begin
          mem_data  <= '0;
          mem_wstrb <= '0;
          lane      <= '0;
          // Address only advances when another word follows, so a full-depth load never wraps.
          if (remaining == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state    <= S_DATA;
            rx_ready <= 1'b1;
            mem_addr <= mem_addr + 1'b1;
          end
        end
        S_DONE: begin
          state     <= S_LEN;
          rx_ready  <= 1'b1;
          cpu_rst_n <= 1'b1;
        end
        S_ERROR: begin
          rx_ready  <= 1'b1;
          error     <= 1'b1;
          cpu_rst_n <= 1'b0;
        end
        default: state <= S_LEN;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes/done pulses are queued as streams are driven
// and matched against the DUT write port.
module tb_prog_loader;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_data;
  logic [3:0]    mem_wstrb;
  logic          mem_we;
  logic          cpu_rst_n;
  logic          done;
  logic          error;

  prog_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wstrb(mem_wstrb), .mem_we(mem_we),
    .cpu_rst_n(cpu_rst_n), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    bit          after_we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } ev_t;

  ev_t        sb[$];
  ev_t        mon_ev;
  logic [7:0] payload[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         wr_count = 0;
  bit         prev_we = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_we = 1'b0;
    end else begin
      if (mem_we) begin
        wr_count++;
        if (sb.size() == 0) chk("spurious_we", 32'(mem_we), 32'd0);
        else begin
          mon_ev = sb.pop_front();
          chk("we_kind", 32'(mon_ev.is_done), 32'd0);
          chk("wr_addr", 32'(mem_addr), mon_ev.addr);
          chk("wr_data", mem_data, mon_ev.data);
          chk("wr_strb", 32'(mem_wstrb), 32'(mon_ev.strb));
        end
      end
      if (done) begin
        if (sb.size() == 0) chk("spurious_done", 32'(done), 32'd0);
        else begin
          mon_ev = sb.pop_front();
          chk("done_kind", 32'(mon_ev.is_done), 32'd1);
          chk("done_latency", 32'(prev_we), 32'(mon_ev.after_we));
        end
      end
      prev_we = mem_we;
    end
  end

  task automatic push_expected();
    ev_t  e;
    int   lane = 0;
    int   addr = 0;
    e = '{default: '0};
    for (int i = 0; i < payload.size(); i++) begin
      e.data[8*lane +: 8] = payload[i];
      e.strb[lane]        = 1'b1;
      lane++;
      if (lane == 4 || i == payload.size() - 1) begin
        e.is_done = 1'b0;
        e.addr    = addr;
        sb.push_back(e);
        addr++;
        lane = 0;
        e    = '{default: '0};
      end
    end
    e.is_done  = 1'b1;
    e.after_we = (payload.size() > 0);
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t = 0;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      chk("ready_timeout", 32'(rx_ready), 32'd1);
      rx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_load(input logic [31:0] len, input int maxgap);
    for (int i = 0; i < 4; i++) begin
      send(len[8*i +: 8], 0);
      if (i == 0) chk("cpu_rst_low_hdr", 32'(cpu_rst_n), 32'd0);
    end
    for (int i = 0; i < payload.size(); i++)
      send(payload[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_vals();
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", mem_data, 32'd0);
    chk("rst_strb", 32'(mem_wstrb), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(rx_ready), 32'd1);
    chk("post_rst_cpu", 32'(cpu_rst_n), 32'd1);

    // two full words
    payload = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    push_expected();
    run_load(32'd8, 0);
    drain();
    @(negedge clk);
    chk("len8_cpu_release", 32'(cpu_rst_n), 32'd1);

    // trailing partial word
    payload = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    push_expected();
    run_load(32'd5, 0);
    drain();

    // empty image
    payload = {};
    push_expected();
    run_load(32'd0, 0);
    chk("len0_done", 32'(done), 32'd1);
    drain();

    // full depth with random valid gaps
    w0 = wr_count;
    payload = {};
    for (int i = 0; i < DEPTH; i++) payload.push_back(8'($urandom_range(0, 255)));
    push_expected();
    run_load(32'(DEPTH), 3);
    drain();
    chk("full_write_count", 32'(wr_count - w0), 32'(DEPTH / 4));

    // oversize length
    w0 = wr_count;
    payload = {};
    run_load(32'(DEPTH + 1), 0);
    chk("err_flag", 32'(error), 32'd1);
    chk("err_cpu_rst", 32'(cpu_rst_n), 32'd0);
    for (int i = 0; i < 20; i++) send(8'(i), 0);
    chk("err_ready", 32'(rx_ready), 32'd1);
    chk("err_no_writes", 32'(wr_count - w0), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);
    chk("err_cleared", 32'(error), 32'd0);

    // reset in the middle of a load
    payload = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_expected();
    void'(sb.pop_back());
    run_load(32'd8, 0);
    send(8'h05, 0);
    send(8'h06, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals();
    chk("midrst_sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();
    rst_n = 1'b1;
    @(negedge clk);
    payload = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    push_expected();
    run_load(32'd4, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
